// File: rtl/fwd_hazard_unit_pkg.sv
// Shared definitions for the forwarding / hazard unit: stage indices,
// stall-episode FSM states and the saturating counter helper.
package fwd_pkg;

  // Forwarding stage indices, youngest first.
  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  // Stall-episode tracking states.
  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } fsm_state_e;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
    logic [63:0] max_v;
    if (w >= 32'd64) begin
      max_v = {64{1'b1}};
    end else begin
      max_v = (64'd1 << w) - 64'd1;
    end
    if (v >= max_v) begin
      sat_inc = max_v;
    end else begin
      sat_inc = v + 64'd1;
    end
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_port.sv
// One read port: picks the youngest matching producer, decides whether its
// value is available yet, and muxes the operand.
module fwd_port
  import fwd_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NFWD = 3
) (
  input  logic [NFWD*5-1:0]    i_st_rd,
  input  logic [NFWD-1:0]      i_st_we,
  input  logic [NFWD-1:0]      i_st_is_load,
  input  logic [NFWD*XLEN-1:0] i_st_wdata,
  input  logic                 i_mem_rvalid,
  input  logic [4:0]           i_rs,
  input  logic                 i_rs_used,
  input  logic [XLEN-1:0]      i_rf_rdata,
  output logic [XLEN-1:0]      o_op_data,
  output logic                 o_fwd_hit,
  output logic                 o_hazard
);

  logic            w_found;
  logic            w_not_ready;
  logic [XLEN-1:0] w_data;

  // Priority search: the first (youngest) writing stage that targets rs wins;
  // x0 is never a forwarding target.
  always_comb begin
    w_found     = 1'b0;
    w_not_ready = 1'b0;
    w_data      = '0;
    for (int s = 0; s < NFWD; s++) begin
      if (!w_found && i_st_we[s] &&
          (i_st_rd[s*5 +: 5] == i_rs) && (i_st_rd[s*5 +: 5] != 5'd0)) begin
        w_found     = 1'b1;
        w_data      = i_st_wdata[s*XLEN +: XLEN];
        w_not_ready = ((s == STG_EX) && i_st_is_load[s]) ||
                      ((s == STG_MEM) && i_st_is_load[s] && !i_mem_rvalid);
      end else begin
        w_found = w_found;
      end
    end
  end

  // Operand mux: forward a ready producer, flag a hazard for a pending load.
  always_comb begin
    o_op_data = i_rf_rdata;
    o_fwd_hit = 1'b0;
    o_hazard  = 1'b0;
    if (i_rs_used && w_found) begin
      if (w_not_ready) begin
        o_hazard = 1'b1;
      end else begin
        o_op_data = w_data;
        o_fwd_hit = 1'b1;
      end
    end else begin
      o_op_data = i_rf_rdata;
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard-detection unit beside the ID stage. Per-port muxing
// is combinational; stall-episode FSM, watchdog and performance counters are
// registered.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int NREAD     = 2,
  parameter int NFWD      = 3,
  parameter int MAX_STALL = 64,
  parameter int CNT_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NFWD*5-1:0]     st_rd,
  input  logic [NFWD-1:0]       st_we,
  input  logic [NFWD-1:0]       st_is_load,
  input  logic [NFWD*XLEN-1:0]  st_wdata,
  input  logic                  mem_rvalid,
  input  logic                  flush,
  input  logic [NREAD*5-1:0]    rs,
  input  logic [NREAD-1:0]      rs_used,
  input  logic [NREAD*XLEN-1:0] rf_rdata,
  output logic [NREAD*XLEN-1:0] op_data,
  output logic [NREAD-1:0]      fwd_hit,
  output logic                  stall_id,
  output logic                  bubble_ex,
  output logic                  stall_timeout,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic [CNT_W-1:0]      fwd_events
);

  // Consecutive-stall counter only needs to reach MAX_STALL-1.
  localparam int           CW       = (MAX_STALL > 2) ? $clog2(MAX_STALL) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_STALL - 1);

  logic [NREAD-1:0] w_port_hit;
  logic [NREAD-1:0] w_hazard;
  logic             w_stall_req;

  fsm_state_e       r_state;
  fsm_state_e       w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic             r_timeout;
  logic             w_timeout_nxt;
  logic [CNT_W-1:0] r_stall_cycles;
  logic [CNT_W-1:0] w_stall_cycles_nxt;
  logic [CNT_W-1:0] r_fwd_events;
  logic [CNT_W-1:0] w_fwd_events_nxt;

  genvar p;
  generate
    for (p = 0; p < NREAD; p++) begin : g_port
      fwd_port #(
        .XLEN (XLEN),
        .NFWD (NFWD)
      ) u_port (
        .i_st_rd      (st_rd),
        .i_st_we      (st_we),
        .i_st_is_load (st_is_load),
        .i_st_wdata   (st_wdata),
        .i_mem_rvalid (mem_rvalid),
        .i_rs         (rs[p*5 +: 5]),
        .i_rs_used    (rs_used[p]),
        .i_rf_rdata   (rf_rdata[p*XLEN +: XLEN]),
        .o_op_data    (op_data[p*XLEN +: XLEN]),
        .o_fwd_hit    (w_port_hit[p]),
        .o_hazard     (w_hazard[p])
      );
    end
  endgenerate

  // A redirect kills the stalled instruction, so flush overrides any hazard.
  assign w_stall_req = (|w_hazard) && !flush;
  assign stall_id    = w_stall_req;
  assign bubble_ex   = w_stall_req;
  // The instruction in ID does not issue while stalled, so no hit is reported.
  assign fwd_hit     = w_port_hit & {NREAD{!w_stall_req}};

  assign stall_timeout = r_timeout;
  assign stall_cycles  = r_stall_cycles;
  assign fwd_events    = r_fwd_events;

  // Next-state logic for the stall FSM, watchdog and performance counters.
  always_comb begin
    w_state_nxt        = r_state;
    w_cnt_nxt          = r_cnt;
    w_timeout_nxt      = r_timeout;
    w_stall_cycles_nxt = r_stall_cycles;
    w_fwd_events_nxt   = r_fwd_events;

    case (r_state)
      RUN: begin
        if (w_stall_req) begin
          w_state_nxt = STALL;
        end else begin
          w_state_nxt = RUN;
        end
      end
      STALL: begin
        if (w_stall_req) begin
          w_state_nxt = STALL;
        end else begin
          w_state_nxt = RUN;
        end
      end
      default: w_state_nxt = RUN;
    endcase

    if (w_stall_req) begin
      if (r_cnt == CNT_LAST) begin
        w_cnt_nxt     = CNT_LAST;
        w_timeout_nxt = 1'b1;
      end else begin
        w_cnt_nxt = r_cnt + CW'(1'b1);
      end
      w_stall_cycles_nxt = CNT_W'(sat_inc(64'(r_stall_cycles), CNT_W));
    end else begin
      w_cnt_nxt = '0;
    end

    if (|fwd_hit) begin
      w_fwd_events_nxt = CNT_W'(sat_inc(64'(r_fwd_events), CNT_W));
    end else begin
      w_fwd_events_nxt = r_fwd_events;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= RUN;
      r_cnt          <= '0;
      r_timeout      <= 1'b0;
      r_stall_cycles <= '0;
      r_fwd_events   <= '0;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_timeout      <= w_timeout_nxt;
      r_stall_cycles <= w_stall_cycles_nxt;
      r_fwd_events   <= w_fwd_events_nxt;
    end
  end

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard-detection unit for the 5-stage RISC-V pipeline, sitting beside the ID stage. For NREAD register read ports it selects the youngest in-flight producer among NFWD later stages, detects load-use and slow-memory hazards, and drives the pipeline stall/bubble controls. It tracks the stall episode in a small FSM with a watchdog and keeps saturating performance counters.

## Interface
- XLEN, 32, datapath width
- NREAD, 2, number of ID read ports (rs1, rs2, …)
- NFWD, 3, forwarding stages; index 0=EX, 1=MEM, 2..NFWD-1 = WB and later (min 2)
- MAX_STALL, 64, consecutive stall cycles before watchdog fires (≥2)
- CNT_W, 32, performance counter width
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- st_rd  in  NFWD*5  destination register per stage
- st_we  in  NFWD  register-write enable per stage
- st_is_load  in  NFWD  stage holds a load
- st_wdata  in  NFWD*XLEN  result per stage (MEM slice = load data when mem_rvalid)
- mem_rvalid  in  1  load in MEM has its data this cycle
- flush  in  1  branch/jump redirect; kills ID and EX contents
- rs  in  NREAD*5  source register per read port
- rs_used  in  NREAD  port actually reads its source
- rf_rdata  in  NREAD*XLEN  register-file read data
- op_data  out  NREAD*XLEN  operand after forwarding
- fwd_hit  out  NREAD  port takes a forwarded value
- stall_id  out  1  hold PC and IF/ID
- bubble_ex  out  1  load NOP into ID/EX
- stall_timeout  out  1  sticky watchdog error
- stall_cycles  out  CNT_W  saturating count of stalled cycles
- fwd_events  out  CNT_W  saturating count of cycles with any fwd_hit

## Operation
- Per port p, match[s] = st_we[s] && st_rd[s]==rs[p] && st_rd[s]!=0. Source = lowest s with match (youngest wins).
- No match or rs_used[p]=0: op_data=rf_rdata, fwd_hit=0.
- Match at s, data ready: op_data=st_wdata[s], fwd_hit=1. Ready unless (s==0 && st_is_load[0]) or (s==1 && st_is_load[1] && !mem_rvalid).
- Match at s, not ready: port hazard; op_data=rf_rdata (don't-care), fwd_hit=0.
- Older ready match behind a younger not-ready load never forwards; the port stalls.
- stall_req = OR of port hazards && !flush. stall_id = bubble_ex = stall_req.
- FSM: RUN → STALL when stall_req; STALL stays while stall_req, returns to RUN when !stall_req or flush. Consecutive counter cnt counts cycles in STALL, cleared on RUN.
- Watchdog: stall_req with cnt==MAX_STALL-1 sets stall_timeout; held until reset. Stalling continues (no forced release).
- stall_cycles +1 each cycle stall_req=1; fwd_events +1 each cycle any fwd_hit=1 (hits are 0 in stalled cycles); both saturate at all-ones.

## Timing
- Forwarding mux, stall_id, bubble_ex: combinational, same cycle, 0 latency.
- FSM, cnt, stall_timeout, counters: update on rising clk edge.
- Reset (rst_n=0 at edge): FSM=RUN, cnt=0, stall_timeout=0, stall_cycles=0, fwd_events=0. Combinational outputs follow inputs during reset.
- Reset mid-stall: next cycle FSM=RUN, cnt=0; stall_id still re-evaluates from inputs.
- Load-use with 1-cycle memory: exactly 1 stall cycle; consumer then forwards from MEM.
- Each extra cycle mem_rvalid=0 adds one stall cycle.
- flush and hazard same cycle: flush wins; no stall, FSM→RUN, counters not incremented.
- Both ports hazard on the same load: single stall per cycle, counted once.

## Structure
- Package fwd_pkg: stage index constants (STG_EX=0, STG_MEM=1, STG_WB=2), FSM state enum {RUN, STALL}, saturating-increment function.
- Sub-module fwd_port: one port's priority match, ready check, and mux (outputs op_data, fwd_hit, hazard). Instantiated NREAD times by generate.
- Top holds the FSM, watchdog, and counters.

## Test plan
- EX ALU writes x5=0x11, MEM writes x5=0x22, port0 rs=5 → op_data0=0x11, fwd_hit0=1, no stall, fwd_events +1.
- EX load to x7, port1 rs=7 → stall_id=bubble_ex=1 for 1 cycle; next cycle MEM load with mem_rvalid=1, data 0xABCD → op_data1=0xABCD, stall_cycles=1.
- Load in MEM to x3 with mem_rvalid low 4 cycles, rs=3 → 4 stall cycles, FSM STALL throughout, then forward; stall_cycles=4.
- rs=0 with st_rd=0, st_we=1 everywhere → op_data=rf_rdata, fwd_hit=0; rs_used=0 against EX load match → no stall.
- Hazard with flush=1 → stall_id=0, counters unchanged; then hold mem_rvalid=0 for 64 cycles (MAX_STALL=64) → stall_timeout=1 from cycle 65, sticky until rst_n=0.
- stall_cycles preloaded near all-ones via CNT_W=4, run 20 stall cycles → saturates at 15.
